// File: rtl/wave_lut_seq.sv
// Phase-stepped waveform generator: counts rising edges of div_clk through a
// 360-step phase and maps the phase to an 8-bit sine/saw/triangle/square sample.
module wave_lut_seq #(
   parameter int STEPS = 360,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          div_clk,
   input  logic          gate,
   input  logic [1:0]    wave_sel,
   output logic [DW-1:0] dac,
   output logic          sample_stb,
   output logic [8:0]    phase
);

   localparam logic [8:0] LAST = 9'(STEPS - 1);

   logic          div_q;
   logic          gate_q;
   logic          pend;
   logic [1:0]    wave_reg;
   logic          step;
   logic [6:0]    qidx;
   logic          neg;
   logic [7:0]    qv;
   logic [8:0]    tri_p;
   logic [DW-1:0] sine_v;
   logic [DW-1:0] sample;

   // Quarter-wave table: 128 + round(127*sin(k degrees)), k = 0..90.
   function automatic logic [7:0] qlut(input logic [6:0] k);
      case (k)
         7'd0:  qlut = 8'd128; 7'd1:  qlut = 8'd130; 7'd2:  qlut = 8'd132; 7'd3:  qlut = 8'd135;
         7'd4:  qlut = 8'd137; 7'd5:  qlut = 8'd139; 7'd6:  qlut = 8'd141; 7'd7:  qlut = 8'd143;
         7'd8:  qlut = 8'd146; 7'd9:  qlut = 8'd148; 7'd10: qlut = 8'd150; 7'd11: qlut = 8'd152;
         7'd12: qlut = 8'd154; 7'd13: qlut = 8'd157; 7'd14: qlut = 8'd159; 7'd15: qlut = 8'd161;
         7'd16: qlut = 8'd163; 7'd17: qlut = 8'd165; 7'd18: qlut = 8'd167; 7'd19: qlut = 8'd169;
         7'd20: qlut = 8'd171; 7'd21: qlut = 8'd174; 7'd22: qlut = 8'd176; 7'd23: qlut = 8'd178;
         7'd24: qlut = 8'd180; 7'd25: qlut = 8'd182; 7'd26: qlut = 8'd184; 7'd27: qlut = 8'd186;
         7'd28: qlut = 8'd188; 7'd29: qlut = 8'd190; 7'd30: qlut = 8'd192; 7'd31: qlut = 8'd193;
         7'd32: qlut = 8'd195; 7'd33: qlut = 8'd197; 7'd34: qlut = 8'd199; 7'd35: qlut = 8'd201;
         7'd36: qlut = 8'd203; 7'd37: qlut = 8'd204; 7'd38: qlut = 8'd206; 7'd39: qlut = 8'd208;
         7'd40: qlut = 8'd210; 7'd41: qlut = 8'd211; 7'd42: qlut = 8'd213; 7'd43: qlut = 8'd215;
         7'd44: qlut = 8'd216; 7'd45: qlut = 8'd218; 7'd46: qlut = 8'd219; 7'd47: qlut = 8'd221;
         7'd48: qlut = 8'd222; 7'd49: qlut = 8'd224; 7'd50: qlut = 8'd225; 7'd51: qlut = 8'd227;
         7'd52: qlut = 8'd228; 7'd53: qlut = 8'd229; 7'd54: qlut = 8'd231; 7'd55: qlut = 8'd232;
         7'd56: qlut = 8'd233; 7'd57: qlut = 8'd235; 7'd58: qlut = 8'd236; 7'd59: qlut = 8'd237;
         7'd60: qlut = 8'd238; 7'd61: qlut = 8'd239; 7'd62: qlut = 8'd240; 7'd63: qlut = 8'd241;
         7'd64: qlut = 8'd242; 7'd65: qlut = 8'd243; 7'd66: qlut = 8'd244; 7'd67: qlut = 8'd245;
         7'd68: qlut = 8'd246; 7'd69: qlut = 8'd247; 7'd70: qlut = 8'd247; 7'd71: qlut = 8'd248;
         7'd72: qlut = 8'd249; 7'd73: qlut = 8'd249; 7'd74: qlut = 8'd250; 7'd75: qlut = 8'd251;
         7'd76: qlut = 8'd251; 7'd77: qlut = 8'd252; 7'd78: qlut = 8'd252; 7'd79: qlut = 8'd253;
         7'd80: qlut = 8'd253; 7'd81: qlut = 8'd253; 7'd82: qlut = 8'd254; 7'd83: qlut = 8'd254;
         7'd84: qlut = 8'd254; 7'd85: qlut = 8'd255; 7'd86: qlut = 8'd255; 7'd87: qlut = 8'd255;
         7'd88: qlut = 8'd255; 7'd89: qlut = 8'd255; 7'd90: qlut = 8'd255;
         default: qlut = 8'd128;
      endcase
   endfunction

   assign step = div_clk & ~div_q;

   // Sample for the current phase, folded onto the quarter-wave table for sine.
   always_comb begin
      qidx = '0;
      neg  = 1'b0;
      if (phase <= 9'd90) begin
         qidx = phase[6:0];
      end else if (phase < 9'd180) begin
         qidx = 7'(9'd180 - phase);
      end else if (phase <= 9'd270) begin
         qidx = 7'(phase - 9'd180);
         neg  = 1'b1;
      end else begin
         qidx = 7'(9'd360 - phase);
         neg  = 1'b1;
      end
      qv     = qlut(qidx);
      sine_v = DW'(neg ? (9'd256 - {1'b0, qv}) : {1'b0, qv});
      tri_p  = (phase < 9'd180) ? phase : (9'd359 - phase);
      case (wave_reg)
         2'b00:   sample = sine_v;
         2'b01:   sample = DW'((17'(phase) * 17'd181) >> 8);
         2'b10:   sample = DW'((17'(tri_p) * 17'd181) >> 7);
         default: sample = (phase < 9'd180) ? DW'(8'hFF) : DW'(8'h00);
      endcase
   end

   // pend marks that the phase register holds a fresh sample to publish next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase      <= '0;
         dac        <= DW'(8'd128);
         sample_stb <= 1'b0;
         div_q      <= 1'b1;
         gate_q     <= 1'b1;
         pend       <= 1'b0;
         wave_reg   <= 2'b00;
      end else begin
         div_q  <= div_clk;
         gate_q <= gate;
         if (!gate) begin
            phase      <= '0;
            pend       <= 1'b0;
            sample_stb <= 1'b0;
            dac        <= DW'(8'd128);
         end else begin
            if (step) begin
               phase    <= (phase == LAST) ? '0 : phase + 9'd1;
               wave_reg <= wave_sel;
               pend     <= 1'b1;
            end else begin
               // A gate rise re-emits the held phase-0 sample.
               pend <= ~gate_q;
            end
            sample_stb <= pend;
            if (pend) dac <= sample;
         end
      end
   end

endmodule

// File: tb/tb_wave_lut_seq.sv
// Bench for wave_lut_seq: directed sweeps plus random stimulus, checked every
// cycle against a behavioural model built from trig and plain arithmetic.
module tb_wave_lut_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       div_clk;
   logic       gate;
   logic [1:0] wave_sel;
   logic [7:0] dac;
   logic       sample_stb;
   logic [8:0] phase;

   int n_checks = 0;
   int n_fail   = 0;
   int stb_total = 0;

   // model state
   int         edge_n = 0;
   int         m_phase, m_dac, m_stb, m_wave;
   bit         m_div, m_gate, m_init = 1'b0;
   bit         m_step;
   logic [7:0] exp_q[$];
   int         due_q[$];

   wave_lut_seq #(.STEPS(360), .DW(8)) dut (
      .clk(clk), .rst(rst), .div_clk(div_clk), .gate(gate), .wave_sel(wave_sel),
      .dac(dac), .sample_stb(sample_stb), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_sample(input int p, input int w);
      real s;
      int  mag;
      case (w)
         0: begin
            s   = $sin(2.0 * 3.14159265358979 * real'(p) / 360.0);
            mag = $rtoi($floor(127.0 * ((s < 0.0) ? -s : s) + 0.5 + 1.0e-6));
            return (s >= 0.0) ? 128 + mag : 128 - mag;
         end
         1: return (p * 181) >> 8;
         2: return (p < 180) ? (p * 181) >> 7 : ((359 - p) * 181) >> 7;
         default: return (p < 180) ? 255 : 0;
      endcase
   endfunction

   // Behavioural model, advanced on each rising clk with the pre-edge inputs.
   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         m_phase = 0; m_dac = 128; m_stb = 0; m_wave = 0;
         m_div = 1'b1; m_gate = 1'b1; m_init = 1'b1;
         exp_q.delete(); due_q.delete();
      end else if (m_init) begin
         m_step = div_clk && !m_div;
         m_div  = div_clk;
         m_stb  = 0;
         if (!gate) begin
            m_phase = 0; m_dac = 128;
            exp_q.delete(); due_q.delete();
         end else begin
            if (due_q.size() > 0 && due_q[0] == edge_n) begin
               m_dac = int'(exp_q.pop_front());
               void'(due_q.pop_front());
               m_stb = 1;
            end
            if (m_step) begin
               m_phase = (m_phase + 1) % 360;
               m_wave  = int'(wave_sel);
               exp_q.push_back(8'(ref_sample(m_phase, m_wave)));
               due_q.push_back(edge_n + 1);
            end else if (!m_gate) begin
               exp_q.push_back(8'(ref_sample(m_phase, m_wave)));
               due_q.push_back(edge_n + 1);
            end
         end
         m_gate = gate;
      end
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (m_init) begin
         check("dac", int'(dac), m_dac);
         check("sample_stb", int'(sample_stb), m_stb);
         check("phase", int'(phase), m_phase);
         if (sample_stb) stb_total++;
      end
   end

   task automatic pulse();
      @(negedge clk); div_clk = 1'b1;
      @(negedge clk); div_clk = 1'b0;
   endtask

   function automatic int lit_point(input int sel, input int p);
      case ({sel[1:0], p[8:0]})
         {2'd0, 9'd90}:  return 255;
         {2'd0, 9'd180}: return 128;
         {2'd0, 9'd270}: return 1;
         {2'd1, 9'd359}: return 253;
         {2'd2, 9'd179}: return 253;
         {2'd2, 9'd180}: return 253;
         {2'd2, 9'd359}: return 0;
         {2'd3, 9'd179}: return 255;
         {2'd3, 9'd180}: return 0;
         default:        return -1;
      endcase
   endfunction

   task automatic sweep(input int sel);
      int snap;
      int lit;
      wave_sel = 2'(sel);
      snap = stb_total;
      for (int i = 1; i <= 360; i++) begin
         pulse();
         check("sweep_phase", int'(phase), i % 360);
         lit = lit_point(sel, i % 360);
         if (lit >= 0) begin
            @(negedge clk);
            check($sformatf("lit_w%0d_p%0d", sel, i % 360), int'(dac), lit);
         end
      end
      repeat (2) @(negedge clk);
      check("sweep_strobes", stb_total - snap, 360);
   endtask

   initial begin
      int snap;
      rst = 1'b1; div_clk = 1'b1; gate = 1'b1; wave_sel = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dac", int'(dac), 128);
      check("rst_phase", int'(phase), 0);
      div_clk = 1'b0;
      repeat (2) @(negedge clk);
      check("no_stb_before_edge", stb_total, 0);

      // pin the model itself
      check("ref_sine_10", ref_sample(10, 0), 150);
      check("ref_sine_30", ref_sample(30, 0), 192);
      check("ref_sine_210", ref_sample(210, 0), 64);
      check("ref_saw_359", ref_sample(359, 1), 253);

      for (int w = 0; w < 4; w++) sweep(w);

      // wave_sel change only takes effect at the next step
      wave_sel = 2'b00;
      repeat (10) pulse();
      @(negedge clk);
      check("sel_pre", int'(dac), 150);
      wave_sel = 2'b11;
      repeat (3) @(negedge clk);
      check("sel_hold", int'(dac), 150);
      pulse();
      @(negedge clk);
      check("sel_phase", int'(phase), 11);
      check("sel_new", int'(dac), 255);

      // gate drop at phase 100
      repeat (89) pulse();
      check("gate_p100", int'(phase), 100);
      gate = 1'b0;
      @(negedge clk);
      check("gate_dac", int'(dac), 128);
      check("gate_phase", int'(phase), 0);
      snap = stb_total;
      repeat (3) pulse();
      check("gate_no_stb", stb_total - snap, 0);
      gate = 1'b1;
      repeat (4) @(negedge clk);
      pulse();
      check("gate_rise_phase", int'(phase), 1);

      // back-to-back steps from phase 0
      gate = 1'b0;
      repeat (2) @(negedge clk);
      gate = 1'b1;
      repeat (4) @(negedge clk);
      snap = stb_total;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk); div_clk = ~div_clk;
      end
      repeat (3) @(negedge clk);
      check("b2b_phase", int'(phase), 40);
      check("b2b_strobes", stb_total - snap, 400);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         div_clk = 1'($urandom_range(0, 1));
         gate    = ($urandom_range(0, 15) != 0);
         rst     = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 49) == 0) wave_sel = 2'($urandom_range(0, 3));
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
